// File: rtl/i2s_mstr_tx.sv
// I2S master transmitter: divides clk down to sclk/ws and serializes left/right
// samples MSB-first in Philips I2S format from a one-deep holding buffer.
module i2s_mstr_tx #(
    parameter int unsigned SCLK_DIV = 16,
    parameter int unsigned DATA_W   = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] lft_smpl,
    input  logic [DATA_W-1:0] rght_smpl,
    input  logic              smpl_vld,
    output logic              smpl_rdy,
    output logic              I2S_sclk,
    output logic              I2S_ws,
    output logic              I2S_data,
    output logic              frm_strt,
    output logic              undrn
);

    localparam int unsigned DIV_W = $clog2(SCLK_DIV);

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    buf_state_t        buf_state, buf_nxt;
    logic [DIV_W-1:0]  div_cnt;
    logic              div_tc;
    logic              fall;
    logic              frame_go;
    logic              accept;
    logic [5:0]        bit_cnt;
    logic [5:0]        bit_nxt;
    logic [DATA_W-1:0] hold_l, hold_r;
    logic [63:0]       shreg;
    logic [63:0]       frame_img;

    assign div_tc   = (div_cnt == DIV_W'(SCLK_DIV - 1));
    assign fall     = div_tc && I2S_sclk;
    assign bit_nxt  = bit_cnt + 6'd1;
    assign frame_go = fall && (bit_cnt == 6'd63);
    assign smpl_rdy = (buf_state == BUF_EMPTY);
    assign accept   = smpl_vld && smpl_rdy;

    // Whole 64-slot frame image: each sample left-justified in its 32-bit slot.
    always_comb begin
        frame_img              = '0;
        frame_img[63 -: DATA_W] = hold_l;
        frame_img[31 -: DATA_W] = hold_r;
    end

    // Frame start drains the buffer; an accept in the same clk refills it.
    always_comb begin
        buf_nxt = buf_state;
        case (buf_state)
            BUF_EMPTY: if (accept)   buf_nxt = BUF_FULL;
            BUF_FULL:  if (frame_go) buf_nxt = BUF_EMPTY;
            default:                 buf_nxt = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_state <= BUF_EMPTY;
        end else begin
            buf_state <= buf_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            I2S_sclk <= 1'b0;
            I2S_ws   <= 1'b0;
            I2S_data <= 1'b0;
            frm_strt <= 1'b0;
            undrn    <= 1'b0;
            bit_cnt  <= 6'd63;
            hold_l   <= '0;
            hold_r   <= '0;
            shreg    <= '0;
        end else begin
            frm_strt <= frame_go;
            undrn    <= frame_go && (buf_state == BUF_EMPTY);
            div_cnt  <= div_tc ? '0 : div_cnt + 1'b1;
            if (div_tc) begin
                I2S_sclk <= ~I2S_sclk;
            end
            if (accept) begin
                hold_l <= lft_smpl;
                hold_r <= rght_smpl;
            end
            if (fall) begin
                bit_cnt <= bit_nxt;
                I2S_ws  <= (bit_nxt >= 6'd31) && (bit_nxt <= 6'd62);
                // Frame image is sampled before any same-clk accept lands in hold_*.
                if (frame_go) begin
                    I2S_data <= frame_img[63];
                    shreg    <= {frame_img[62:0], 1'b0};
                end else begin
                    I2S_data <= shreg[63];
                    shreg    <= {shreg[62:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_mstr_tx.sv
// Directed bench for i2s_mstr_tx with a behavioural I2S receiver sampling on sclk rise.
module tb_i2s_mstr_tx;

    logic        clk;
    logic        rst_n;
    logic [23:0] lft_smpl;
    logic [23:0] rght_smpl;
    logic        smpl_vld;
    logic        smpl_rdy;
    logic        I2S_sclk;
    logic        I2S_ws;
    logic        I2S_data;
    logic        frm_strt;
    logic        undrn;

    int checks;
    int failures;

    int st_cyc, st_ws, st_data, st_rise, st_undrn;

    logic [47:0] rx_q[$];
    int          pad_bad;

    i2s_mstr_tx #(.SCLK_DIV(2), .DATA_W(24)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lft_smpl  (lft_smpl),
        .rght_smpl (rght_smpl),
        .smpl_vld  (smpl_vld),
        .smpl_rdy  (smpl_rdy),
        .I2S_sclk  (I2S_sclk),
        .I2S_ws    (I2S_ws),
        .I2S_data  (I2S_data),
        .frm_strt  (frm_strt),
        .undrn     (undrn)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Receiver model: a ws change marks the last bit of the slot just finished.
    initial begin
        logic        ws_prev;
        logic        have_left;
        logic [31:0] sr;
        logic [23:0] left;
        ws_prev   = 1'b0;
        have_left = 1'b0;
        sr        = '0;
        left      = '0;
        pad_bad   = 0;
        forever begin
            @(posedge I2S_sclk or negedge rst_n);
            if (!rst_n) begin
                ws_prev   = 1'b0;
                have_left = 1'b0;
                sr        = '0;
            end else begin
                sr = {sr[30:0], I2S_data};
                if (I2S_ws !== ws_prev) begin
                    if (sr[7:0] != 8'h00) pad_bad++;
                    if (I2S_ws) begin
                        left      = sr[31:8];
                        have_left = 1'b1;
                    end else if (have_left) begin
                        rx_q.push_back({left, sr[31:8]});
                        have_left = 1'b0;
                    end
                end
                ws_prev = I2S_ws;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs from the current negedge up to and including the next frm_strt sample.
    task automatic run_frame();
        logic prev;
        st_cyc = 0; st_ws = 0; st_data = 0; st_rise = 0; st_undrn = 0;
        prev = I2S_sclk;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            if (I2S_ws)             st_ws++;
            if (I2S_data)           st_data++;
            if (I2S_sclk && !prev)  st_rise++;
            prev = I2S_sclk;
            if (undrn)              st_undrn++;
            if (frm_strt) begin
                st_cyc = i;
                return;
            end
        end
    endtask

    function automatic logic [47:0] q_at(input int idx);
        if (idx < rx_q.size()) return rx_q[idx];
        return '1;
    endfunction

    initial begin
        int n, frames, und, rdy_bad, seq_err, last_und;
        bit pending;
        logic [47:0] exp_pair;

        checks = 0; failures = 0;
        rst_n = 1'b0; smpl_vld = 1'b0; lft_smpl = '0; rght_smpl = '0;

        // 1. reset values and idle framing
        repeat (2) @(negedge clk);
        check("rst_sclk", I2S_sclk, 0);
        check("rst_ws",   I2S_ws,   0);
        check("rst_data", I2S_data, 0);
        check("rst_rdy",  smpl_rdy, 1);
        check("rst_frm",  frm_strt, 0);
        check("rst_undrn", undrn,   0);
        rst_n = 1'b1;
        run_frame();
        check("first_frame_clks", st_cyc, 4);
        check("first_frame_undrn", undrn, 1);
        run_frame();
        check("idle_frame_clks", st_cyc,   256);
        check("idle_ws_high",    st_ws,    128);
        check("idle_data_high",  st_data,  0);
        check("idle_sclk_rises", st_rise,  64);
        check("idle_undrn",      st_undrn, 1);

        // 2. single pair
        lft_smpl = 24'hA50F3C; rght_smpl = 24'h5AF0C3; smpl_vld = 1'b1;
        @(negedge clk);
        check("pair_rdy_low", smpl_rdy, 0);
        smpl_vld = 1'b0;
        run_frame();
        check("pair_frame_clks", st_cyc, 255);
        check("pair_no_undrn", st_undrn, 0);
        rx_q.delete(); pad_bad = 0;
        run_frame();
        check("pair_rx_count", rx_q.size(), 1);
        check("pair_rx_data",  q_at(0), {24'hA50F3C, 24'h5AF0C3});
        check("pair_pad",      pad_bad, 0);
        check("pair_next_undrn", st_undrn, 1);

        // 3. 100-pair stream with valid held high
        rx_q.delete(); pad_bad = 0;
        n = 1; lft_smpl = 24'd1; rght_smpl = 24'd1; smpl_vld = 1'b1;
        pending = smpl_rdy;
        frames = 0; und = 0; rdy_bad = 0; last_und = 0;
        for (int i = 0; i < 30000 && frames < 101; i++) begin
            @(negedge clk);
            if (pending) begin
                pending = 1'b0;
                if (n == 100) smpl_vld = 1'b0;
                else begin
                    n++;
                    lft_smpl = 24'(n); rght_smpl = 24'(n);
                end
            end
            if (smpl_vld && smpl_rdy) pending = 1'b1;
            if (frm_strt) begin
                frames++;
                if (frames <= 100 && !smpl_rdy) rdy_bad++;
                if (frames == 101) last_und = int'(undrn);
            end
            if (undrn && frames <= 100) und++;
        end
        check("stream_frames",   frames, 101);
        check("stream_sent",     n, 100);
        check("stream_undrn",    und, 0);
        check("stream_rdy_at_frm", rdy_bad, 0);
        check("stream_end_undrn", last_und, 1);
        check("stream_rx_count", rx_q.size(), 101);
        seq_err = 0;
        for (int k = 0; k <= 100; k++) begin
            exp_pair = (k == 0) ? {24'hA50F3C, 24'h5AF0C3} : {24'(k), 24'(k)};
            if (q_at(k) !== exp_pair) seq_err++;
        end
        check("stream_order", seq_err, 0);
        check("stream_pad", pad_bad, 0);

        // 4. accept coinciding with frame start on an empty buffer
        repeat (255) @(negedge clk);
        lft_smpl = 24'hC0FFEE; rght_smpl = 24'h123456; smpl_vld = 1'b1;
        @(negedge clk);
        smpl_vld = 1'b0;
        check("coinc_frm",   frm_strt, 1);
        check("coinc_undrn", undrn,    1);
        check("coinc_rdy",   smpl_rdy, 0);
        rx_q.delete();
        run_frame();
        check("coinc_next_undrn", st_undrn, 0);
        run_frame();
        check("coinc_rx_count", rx_q.size(), 2);
        check("coinc_retx",     q_at(0), {24'd100, 24'd100});
        check("coinc_new",      q_at(1), {24'hC0FFEE, 24'h123456});

        // 5. async reset mid-right-word (bit_cnt 40) with a full buffer
        lft_smpl = 24'h111111; rght_smpl = 24'h222222; smpl_vld = 1'b1;
        @(negedge clk);
        smpl_vld = 1'b0;
        repeat (159) @(negedge clk);
        check("mid_ws_right", I2S_ws, 1);
        check("mid_rdy_full", smpl_rdy, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sclk",  I2S_sclk, 0);
        check("arst_ws",    I2S_ws,   0);
        check("arst_data",  I2S_data, 0);
        check("arst_rdy",   smpl_rdy, 1);
        check("arst_frm",   frm_strt, 0);
        check("arst_undrn", undrn,    0);
        rx_q.delete(); pad_bad = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_frame();
        check("rerst_first_clks", st_cyc, 4);
        check("rerst_undrn",      undrn,  1);
        check("rerst_ws_left",    I2S_ws, 0);

        // 6. full-scale pair through the receiver model
        lft_smpl = 24'h7FFFFF; rght_smpl = 24'h800000; smpl_vld = 1'b1;
        @(negedge clk);
        smpl_vld = 1'b0;
        run_frame();
        check("fs_no_undrn", st_undrn, 0);
        check("fs_rx_zero",  q_at(0), 48'h0);
        run_frame();
        check("fs_rx_count", rx_q.size(), 2);
        check("fs_rx_data",  q_at(1), {24'h7FFFFF, 24'h800000});
        check("fs_pad",      pad_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
